// File: rtl/slinky_pkg.sv
// Shared constants for the slinky RAM card controller: register offsets,
// pointer step modes and the 7M state sequence within one Apple cycle.
package slinky_pkg;

    localparam logic [3:0] REG_ADDRL = 4'h0;
    localparam logic [3:0] REG_ADDRM = 4'h1;
    localparam logic [3:0] REG_ADDRH = 4'h2;
    localparam logic [3:0] REG_DATA  = 4'h3;
    localparam logic [3:0] REG_CTRL  = 4'h4;
    localparam logic [3:0] REG_BANK  = 4'hF;

    typedef enum logic [1:0] {
        STEP_INC  = 2'b00,
        STEP_DEC  = 2'b01,
        STEP_HOLD = 2'b10
    } step_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_2    = 3'd2,
        S_3    = 3'd3,
        S_4    = 3'd4,
        S_5    = 3'd5,
        S_6    = 3'd6,
        S_7    = 3'd7
    } state_e;

endpackage

// File: rtl/slinky_refresh.sv
// CAS-before-RAS refresh scheduler: one refresh every REF_PERIOD Apple cycles,
// confined to S1..S3 so it never meets a 6502 access in S4..S6.
module slinky_refresh
    import slinky_pkg::*;
#(
    parameter int REF_PERIOD = 13
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  state_e s_i,
    output logic   ref_cas_en_o,
    output logic   ref_ras_en_o
);

    logic [3:0] ref_q;
    logic [3:0] ref_d;

    // Refresh counter advances once per Apple cycle, at the end of S3.
    always_comb begin
        ref_d = ref_q;
        if (s_i == S_3) begin
            if (ref_q == 4'(REF_PERIOD - 1)) begin
                ref_d = 4'd0;
            end else begin
                ref_d = ref_q + 4'd1;
            end
        end else begin
            ref_d = ref_q;
        end
    end

    // Refresh counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ref_q <= 4'd0;
        end else begin
            ref_q <= ref_d;
        end
    end

    assign ref_cas_en_o = (s_i == S_1) && (ref_q == 4'd0);
    assign ref_ras_en_o = (s_i == S_2) && (ref_q == 4'd0);

endmodule

// File: rtl/slinky_dram_ctl.sv
// Apple II slinky RAM card controller: auto-stepping pointer, ROM bank
// register and DRAM RAS/CAS sequencing, all timed from the 7M clock.
module slinky_dram_ctl
    import slinky_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int COL_W      = 11,
    parameter int NBANK      = 2,
    parameter int REF_PERIOD = 13
) (
    input  logic             C7M,
    input  logic             nRES,
    input  logic             PHI1,
    input  logic             nDEVSEL,
    input  logic             nIOSEL,
    input  logic             nIOSTRB,
    input  logic [3:0]       A,
    input  logic             nWE,
    input  logic [7:0]       Din,
    output logic [7:0]       Dout,
    output logic             DOE,
    output logic [COL_W-1:0] RA,
    output logic             nRAS,
    output logic [NBANK-1:0] nCAS,
    output logic [7:0]       Bank,
    output logic             REGEN
);

    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

    logic              phi1_q, phi0seen_q, regen_q, ramsel_q;
    logic              regen_d, ramsel_d;
    state_e            s_q, s_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        bank_q, bank_d;
    logic [1:0]        step_q, step_d;
    logic              nras_q, nras_d, asel_q, asel_d;
    logic [NBANK-1:0]  ncas_q, ncas_d;
    logic [23:0]       addr_ext_s, addr_wr_s;
    logic [BANK_W-1:0] bank_sel_s;
    logic              ramsel_s, reg_wr_s, ref_cas_en_s, ref_ras_en_s;
    logic              unused_strb_s;

    assign unused_strb_s = nIOSTRB;

    slinky_refresh #(.REF_PERIOD(REF_PERIOD)) u_refresh (
        .clk_i        (C7M),
        .rst_ni       (nRES),
        .s_i          (s_q),
        .ref_cas_en_o (ref_cas_en_s),
        .ref_ras_en_o (ref_ras_en_s)
    );

    assign ramsel_s = !nDEVSEL && regen_q && (A == REG_DATA);
    assign reg_wr_s = !nWE && !nDEVSEL && regen_q;

    // Pointer padded to 24 bits with ones so AddrH reads back unused bits as 1.
    always_comb begin
        addr_ext_s               = 24'hFF_FFFF;
        addr_ext_s[ADDR_W-1:0]   = addr_q;
        addr_wr_s                = addr_ext_s;
        bank_sel_s               = '0;
        case (A)
            REG_ADDRL: addr_wr_s[7:0]   = Din;
            REG_ADDRM: addr_wr_s[15:8]  = Din;
            REG_ADDRH: addr_wr_s[23:16] = Din;
            default:   addr_wr_s        = addr_ext_s;
        endcase
        if (NBANK > 1) begin
            bank_sel_s = addr_ext_s[2*COL_W +: BANK_W];
        end else begin
            bank_sel_s = '0;
        end
    end

    // Apple-cycle sequencer: a PHI1 rising edge restarts at S1, S7 saturates.
    always_comb begin
        s_d = s_q;
        if (PHI1 && !phi1_q && phi0seen_q) begin
            s_d = S_1;
        end else if (s_q == S_IDLE || s_q == S_7) begin
            s_d = s_q;
        end else begin
            s_d = state_e'(s_q + 3'd1);
        end
    end

    // Register file, pointer stepping and data-window capture.
    always_comb begin
        addr_d   = addr_q;
        bank_d   = bank_q;
        step_d   = step_q;
        ramsel_d = ramsel_q;
        regen_d  = regen_q;
        if (s_q == S_4 && !nIOSEL) begin
            regen_d = 1'b1;
        end else begin
            regen_d = regen_q;
        end
        if (s_q == S_2 && ramsel_q) begin
            case (step_q)
                STEP_INC: addr_d = addr_q + ADDR_W'(1);
                STEP_DEC: addr_d = addr_q - ADDR_W'(1);
                default:  addr_d = addr_q;
            endcase
            ramsel_d = 1'b0;
        end else if (s_q == S_4) begin
            ramsel_d = ramsel_s;
        end else if (s_q == S_6 && reg_wr_s) begin
            case (A)
                REG_ADDRL, REG_ADDRM, REG_ADDRH: addr_d = addr_wr_s[ADDR_W-1:0];
                REG_CTRL: step_d = Din[1:0];
                REG_BANK: bank_d = Din;
                default:  addr_d = addr_q;
            endcase
        end else begin
            addr_d = addr_q;
        end
    end

    // DRAM strobes: refresh owns S1..S3, the 6502 access owns S4..S6.
    always_comb begin
        nras_d = nras_q;
        ncas_d = ncas_q;
        asel_d = asel_q;
        case (s_q)
            S_1: if (ref_cas_en_s) ncas_d = '0; else ncas_d = ncas_q;
            S_2: begin
                ncas_d = '1;
                if (ref_ras_en_s) nras_d = 1'b0; else nras_d = nras_q;
            end
            S_3: nras_d = 1'b1;
            S_4: begin
                if (ramsel_s) begin
                    nras_d = 1'b0;
                    asel_d = 1'b1;
                end else begin
                    nras_d = nras_q;
                end
            end
            S_5: begin
                if (ramsel_q) begin
                    for (int i = 0; i < NBANK; i++) begin
                        ncas_d[i] = (BANK_W'(i) != bank_sel_s);
                    end
                end else begin
                    ncas_d = ncas_q;
                end
            end
            default: begin
                nras_d = 1'b1;
                ncas_d = '1;
                asel_d = 1'b0;
            end
        endcase
    end

    // State, pointer and strobe registers; reset forces strobes inactive at once.
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            phi1_q     <= 1'b0;
            phi0seen_q <= 1'b0;
            s_q        <= S_IDLE;
            addr_q     <= '0;
            bank_q     <= 8'h00;
            step_q     <= 2'b00;
            regen_q    <= 1'b0;
            ramsel_q   <= 1'b0;
            nras_q     <= 1'b1;
            ncas_q     <= '1;
            asel_q     <= 1'b0;
        end else begin
            phi1_q     <= PHI1;
            phi0seen_q <= phi0seen_q | !PHI1;
            s_q        <= s_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            step_q     <= step_d;
            regen_q    <= regen_d;
            ramsel_q   <= ramsel_d;
            nras_q     <= nras_d;
            ncas_q     <= ncas_d;
            asel_q     <= asel_d;
        end
    end

    // Register readback mux.
    always_comb begin
        case (A)
            REG_ADDRL: Dout = addr_ext_s[7:0];
            REG_ADDRM: Dout = addr_ext_s[15:8];
            REG_ADDRH: Dout = addr_ext_s[23:16];
            REG_CTRL:  Dout = {6'b000000, step_q};
            REG_BANK:  Dout = bank_q;
            default:   Dout = 8'h00;
        endcase
    end

    assign DOE   = s_q[2] && nWE && !nDEVSEL && regen_q && (A != REG_DATA);
    assign RA    = asel_q ? addr_q[COL_W-1:0] : addr_q[2*COL_W-1:COL_W];
    assign nRAS  = nras_q;
    assign nCAS  = ncas_q;
    assign Bank  = bank_q;
    assign REGEN = regen_q;

endmodule

// File: doc/slinky_dram_ctl.md
Name: slinky_dram_ctl

Overview:
- Parametrised successor to the single-chip GR8RAM CPLD logic: Apple II slot "slinky" RAM card controller.
- Provides a 6502-visible auto-stepping address pointer, a ROM bank register, DRAM RAS/CAS/row-column multiplexing, and CAS-before-RAS refresh, all timed from one 7M clock.
- Generalised in address width, number of DRAM CAS banks and refresh period.
- New behaviour: programmable step mode (increment, decrement or hold) and full-width pointer readback.

Parameters:
ADDR_W, 24, pointer width in bits (16..24); bits above the column+row span select the CAS bank.
COL_W, 11, DRAM column/row address width; row = Addr[2*COL_W-1:COL_W], column = Addr[COL_W-1:0].
NBANK, 2, number of CAS lines (power of 2, 1..4); bank = Addr[2*COL_W +: log2(NBANK)].
REF_PERIOD, 13, Apple cycles between refreshes (2..16).

Ports:
C7M  in  1  7.16 MHz clock; all logic rises on posedge.
nRES  in  1  asynchronous active-low reset.
PHI1  in  1  delayed, hold-safe PHI1, synchronous to C7M.
nDEVSEL  in  1  slot $C0nX select, active low.
nIOSEL  in  1  slot $CnXX select, active low.
nIOSTRB  in  1  $C800-$CFFF strobe, active low.
A  in  4  6502 address low nibble.
nWE  in  1  6502 R/W (1 = read).
Din  in  8  6502 data bus in.
Dout  out  8  register readback data.
DOE  out  1  drive Apple data bus.
RA  out  COL_W  DRAM row/column address.
nRAS  out  1  DRAM RAS, active low.
nCAS  out  NBANK  DRAM CAS per bank, active low.
Bank  out  8  ROM bank register.
REGEN  out  1  registers unlocked.

Behaviour:
- Reset (async, nRES=0): S=0, PHI0seen=0, Ref=0, Addr=0, Bank=0, Step=00, REGEN=0, nRAS=1, nCAS=all 1, ASel=0, DOE=0, RAMSELreg=0.
- State counter S[2:0]:
  - PHI0seen is set on any cycle with PHI1=0.
  - S<=1 when PHI1 & ~PHI1reg & PHI0seen; otherwise S=0 holds 0, S=7 holds 7, else S+1.
  - S4..S6 fall in PHI0.
- REGEN: set at end of S4 when nIOSEL=0; cleared only by reset. Every register access requires nDEVSEL=0 & REGEN.
- Register map (A[3:0]):
  - 0 AddrL [7:0].
  - 1 AddrM [15:8].
  - 2 AddrH [ADDR_W-1:16]; reads back with unused high bits = 1.
  - 3 data window (RAM).
  - 4 Ctrl: [1:0] = Step (00 inc, 01 dec, 10/11 hold); reads back {6'b0, Step}.
  - F Bank.
  - Others: reads 8'h00, writes ignored.
- Register writes are latched at end of S6 from Din.
- Readback: DOE = S[2] & nWE & ~nDEVSEL & REGEN & (A != 3). Dout is combinational from A.
- Data window:
  - RAMSEL = ~nDEVSEL & REGEN & A==3; RAMSELreg is captured at end of S4.
  - At end of the next S2 with RAMSELreg=1: Addr steps per Step, modulo 2^ADDR_W (0 dec -> all-ones, all-ones inc -> 0); then RAMSELreg <= 0.
  - A write to AddrL/M/H in the same Apple cycle as a step cannot collide: the step happens at S2, the write at S6.
- DRAM access (RAMSEL during S4):
  - nRAS low at end of S4 through end of S6.
  - ASel = 1 at end of S4 through end of S6; RA = ASel ? column : row.
  - nCAS[bank] low at end of S5 through end of S6; other CAS lines stay high.
  - Outside accesses RA = row.
- Refresh:
  - Ref counts 0..REF_PERIOD-1, advanced at end of S3, wrapping.
  - When Ref==0: all nCAS low at end of S1 through S2; nRAS low at end of S2 through S3; CAS deasserts before RAS.
  - Refresh and access never overlap, because S1..S3 and S4..S6 are disjoint.
- Missing PHI1 edge: S saturates at 7, all strobes deassert, and no refresh or step occurs.
- Reset mid-access: strobes go inactive immediately.

Decomposition:
- Package slinky_pkg holds:
  - register offset constants (REG_ADDRL=0, REG_ADDRM=1, REG_ADDRH=2, REG_DATA=3, REG_CTRL=4, REG_BANK=4'hF);
  - step-mode enum (STEP_INC, STEP_DEC, STEP_HOLD);
  - state constants S_IDLE=0..S_7=7.
- One sub-module, slinky_refresh: owns the Ref counter and emits refresh CAS/RAS enables from S.

Test Plan:
- Reset, then 3 PHI1 periods without PHI1 edge history -> S stays 0, nRAS=nCAS=1, REGEN=0; write to $C0n0 ignored, Addr stays 0.
- IOSEL access, then write AddrL=$FF, AddrM=$FF, AddrH=$FF (ADDR_W=24), Step=inc, then one data-window read -> Addr wraps to $000000; nCAS[1] pulses low for S5..S6 of the access cycle.
- Step=dec, Addr=$000000, two data-window writes -> Addr=$FFFFFE; first access uses row/col of $000000, CAS bank 0.
- Step=hold, 4 data-window reads at Addr=$012345 -> Addr unchanged; AddrH readback = $F1 for ADDR_W=20.
- 26 idle Apple cycles with REF_PERIOD=13 -> exactly 2 refreshes, each with all nCAS low in S2 and nRAS low in S3, CAS released first.
- nRES asserted during S5 of an access -> nRAS, nCAS high and ASel=0 immediately; Addr=0, no step after release.
